// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared constants, next-PC select codes and PC helper functions
//               for the MIPS pipeline front end.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam logic [31:0] c_reset_pc = 32'h8000_0000;
    localparam logic [31:0] c_illop_pc = 32'h8000_0004;
    localparam logic [31:0] c_xadr_pc  = 32'h8000_0008;
    localparam logic [31:0] c_nop      = 32'h0000_0000;

    typedef enum logic [2:0] {
        SEL_SEQ   = 3'd0,
        SEL_BR    = 3'd1,
        SEL_J     = 3'd2,
        SEL_JR    = 3'd3,
        SEL_ILLOP = 3'd4,
        SEL_XADR  = 3'd5,
        SEL_HOLD  = 3'd6
    } next_pc_sel_e;

    // The supervisor bit rides along untouched; the low 31 bits wrap.
    function automatic logic [31:0] f_seq_pc(input logic [31:0] pc);
        return {pc[31], pc[30:0] + 31'd4};
    endfunction

    function automatic logic [31:0] f_branch_target(input logic [31:0] pc,
                                                     input logic [31:0] target);
        return {pc[31], target[30:0]};
    endfunction

    function automatic logic [31:0] f_jump_target(input logic [31:0] pc,
                                                   input logic [25:0] idx);
        return {pc[31:28], idx, 2'b00};
    endfunction

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/if_next_pc.sv
`default_nettype none
// ============================================================================
// Module      : if_next_pc
// Description : Combinational next-PC priority mux for the fetch stage; also
//               reports the IF/ID flush and interrupt-take decisions.
// Revision    : 1.0 - initial release
// ============================================================================
module if_next_pc
    import cpu_pkg::*;
#(
    parameter logic [31:0] ILLOP_PC = c_illop_pc,
    parameter logic [31:0] XADR_PC  = c_xadr_pc
) (
    input  logic [31:0]  i_pc,
    input  logic         i_stall,
    input  logic         i_id_jump,
    input  logic [25:0]  i_id_jump_idx,
    input  logic         i_id_jr,
    input  logic [31:0]  i_id_jr_target,
    input  logic         i_ex_branch_taken,
    input  logic [31:0]  i_ex_branch_target,
    input  logic         i_id_exception,
    input  logic         i_irq,
    output logic [31:0]  o_next_pc,
    output next_pc_sel_e o_sel,
    output logic         o_flush,
    output logic         o_irq_take
);

    logic w_redirect;
    logic w_unused_br_bit;

    // Branch bit 31 is replaced by the current supervisor bit.
    assign w_unused_br_bit = i_ex_branch_target[31];

    assign w_redirect = i_id_exception | i_ex_branch_taken | i_id_jr | i_id_jump;
    assign o_irq_take = i_irq & ~i_pc[31] & ~i_stall & ~w_redirect;

    always_comb begin
        o_next_pc = f_seq_pc(i_pc);
        o_sel     = SEL_SEQ;
        o_flush   = 1'b0;
        if (i_id_exception) begin
            o_next_pc = ILLOP_PC;
            o_sel     = SEL_ILLOP;
            o_flush   = 1'b1;
        end else if (i_ex_branch_taken) begin
            o_next_pc = f_branch_target(i_pc, i_ex_branch_target);
            o_sel     = SEL_BR;
            o_flush   = 1'b1;
        end else if (i_stall) begin
            o_next_pc = i_pc;
            o_sel     = SEL_HOLD;
        end else if (i_id_jr) begin
            o_next_pc = i_id_jr_target;
            o_sel     = SEL_JR;
            o_flush   = 1'b1;
        end else if (i_id_jump) begin
            o_next_pc = f_jump_target(i_pc, i_id_jump_idx);
            o_sel     = SEL_J;
            o_flush   = 1'b1;
        end else if (o_irq_take) begin
            o_next_pc = XADR_PC;
            o_sel     = SEL_XADR;
        end
    end

endmodule : if_next_pc
`default_nettype wire

// File: rtl/if_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_stage
// Description : MIPS instruction-fetch stage: PC register, ROM address and
//               IF/ID pipeline register with stall, flush and IRQ bubbles.
// Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = c_reset_pc,
    parameter logic [31:0] ILLOP_PC = c_illop_pc,
    parameter logic [31:0] XADR_PC  = c_xadr_pc
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_data,
    input  logic        stall,
    input  logic        id_jump,
    input  logic [25:0] id_jump_idx,
    input  logic        id_jr,
    input  logic [31:0] id_jr_target,
    input  logic        ex_branch_taken,
    input  logic [31:0] ex_branch_target,
    input  logic        id_exception,
    input  logic        irq,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid,
    output logic        if_id_irq,
    output logic [31:0] pc
);

    logic [31:0]  r_pc;
    logic [31:0]  r_if_id_instr;
    logic [31:0]  r_if_id_pc_plus4;
    logic         r_if_id_valid;
    logic         r_if_id_irq;

    logic [31:0]  w_next_pc;
    logic [31:0]  w_seq_pc;
    next_pc_sel_e w_sel;
    logic         w_flush;
    logic         w_irq_take;

    assign w_seq_pc = f_seq_pc(r_pc);

    if_next_pc #(
        .ILLOP_PC (ILLOP_PC),
        .XADR_PC  (XADR_PC)
    ) u_next_pc (
        .i_pc               (r_pc),
        .i_stall            (stall),
        .i_id_jump          (id_jump),
        .i_id_jump_idx      (id_jump_idx),
        .i_id_jr            (id_jr),
        .i_id_jr_target     (id_jr_target),
        .i_ex_branch_taken  (ex_branch_taken),
        .i_ex_branch_target (ex_branch_target),
        .i_id_exception     (id_exception),
        .i_irq              (irq),
        .o_next_pc          (w_next_pc),
        .o_sel              (w_sel),
        .o_flush            (w_flush),
        .o_irq_take         (w_irq_take)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc <= RESET_PC;
        end else if (w_sel != SEL_HOLD) begin
            r_pc <= w_next_pc;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_if_id_instr    <= c_nop;
            r_if_id_pc_plus4 <= 32'h0;
            r_if_id_valid    <= 1'b0;
            r_if_id_irq      <= 1'b0;
        end else if (w_flush) begin
            r_if_id_instr    <= c_nop;
            r_if_id_pc_plus4 <= w_seq_pc;
            r_if_id_valid    <= 1'b0;
            r_if_id_irq      <= 1'b0;
        end else if (w_irq_take) begin
            // Bubble carries the return point of the instruction left unfetched.
            r_if_id_instr    <= c_nop;
            r_if_id_pc_plus4 <= w_seq_pc;
            r_if_id_valid    <= 1'b0;
            r_if_id_irq      <= 1'b1;
        end else if (w_sel == SEL_SEQ) begin
            r_if_id_instr    <= rom_data;
            r_if_id_pc_plus4 <= w_seq_pc;
            r_if_id_valid    <= 1'b1;
            r_if_id_irq      <= 1'b0;
        end
    end

    assign pc             = r_pc;
    assign rom_addr       = r_pc;
    assign if_id_instr    = r_if_id_instr;
    assign if_id_pc_plus4 = r_if_id_pc_plus4;
    assign if_id_valid    = r_if_id_valid;
    assign if_id_irq      = r_if_id_irq;

endmodule : if_fetch_stage
`default_nettype wire

// File: tb/tb_if_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_fetch_stage
// Description : Self-checking bench for if_fetch_stage: directed scenarios
//               followed by randomized redirects, stalls and interrupts.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] rom_addr, rom_data;
    logic        stall, id_jump, id_jr, ex_branch_taken, id_exception, irq;
    logic [25:0] id_jump_idx;
    logic [31:0] id_jr_target, ex_branch_target;
    logic [31:0] if_id_instr, if_id_pc_plus4, pc;
    logic        if_id_valid, if_id_irq;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // Reference state, advanced from the fetch rules alone.
    logic [31:0] m_pc, m_instr, m_pc4;
    logic        m_valid, m_irq, m_pc4_def;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_fn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    assign rom_data = rom_fn(rom_addr);

    if_fetch_stage dut (
        .clk              (clk),
        .reset            (rst_n),
        .rom_addr         (rom_addr),
        .rom_data         (rom_data),
        .stall            (stall),
        .id_jump          (id_jump),
        .id_jump_idx      (id_jump_idx),
        .id_jr            (id_jr),
        .id_jr_target     (id_jr_target),
        .ex_branch_taken  (ex_branch_taken),
        .ex_branch_target (ex_branch_target),
        .id_exception     (id_exception),
        .irq              (irq),
        .if_id_instr      (if_id_instr),
        .if_id_pc_plus4   (if_id_pc_plus4),
        .if_id_valid      (if_id_valid),
        .if_id_irq        (if_id_irq),
        .pc               (pc)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc = 32'h8000_0000; m_instr = 32'h0; m_pc4 = 32'h0;
            m_valid = 1'b0; m_irq = 1'b0; m_pc4_def = 1'b1;
        end else begin
            logic [31:0] cur, nxt;
            logic        redirect;
            cur = m_pc;
            nxt = {cur[31], 31'((cur & 32'h7FFF_FFFF) + 32'd4)};
            redirect = id_exception | ex_branch_taken | id_jr | id_jump;
            if (redirect && !(stall && !id_exception && !ex_branch_taken)) begin
                if (id_exception)         m_pc = 32'h8000_0004;
                else if (ex_branch_taken) m_pc = (cur & 32'h8000_0000) | (ex_branch_target & 32'h7FFF_FFFF);
                else if (id_jr)           m_pc = id_jr_target;
                else                      m_pc = (cur & 32'hF000_0000) | {4'h0, id_jump_idx, 2'b00};
                m_instr = 32'h0; m_valid = 1'b0; m_irq = 1'b0; m_pc4_def = 1'b0;
            end else if (stall) begin
                // nothing moves
            end else if (irq && !cur[31]) begin
                m_pc = 32'h8000_0008;
                m_instr = 32'h0; m_valid = 1'b0; m_irq = 1'b1;
                m_pc4 = nxt; m_pc4_def = 1'b1;
            end else begin
                m_pc = nxt;
                m_instr = rom_fn(cur); m_valid = 1'b1; m_irq = 1'b0;
                m_pc4 = nxt; m_pc4_def = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("pc", pc, m_pc);
            check("rom_addr", rom_addr, m_pc);
            check("if_id_instr", if_id_instr, m_instr);
            check("if_id_valid", {31'h0, if_id_valid}, {31'h0, m_valid});
            check("if_id_irq", {31'h0, if_id_irq}, {31'h0, m_irq});
            if (m_pc4_def) check("if_id_pc_plus4", if_id_pc_plus4, m_pc4);
        end
    end

    task automatic clr();
        stall = 0; id_jump = 0; id_jump_idx = '0; id_jr = 0; id_jr_target = '0;
        ex_branch_taken = 0; ex_branch_target = '0; id_exception = 0; irq = 0;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic jr_to(input logic [31:0] t);
        id_jr = 1; id_jr_target = t;
        step();
        clr();
    endtask

    logic [31:0] held;

    initial begin
        clr();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check("rst_pc", pc, 32'h8000_0000);
        check("rst_valid", {31'h0, if_id_valid}, 32'h0);
        check("rst_instr", if_id_instr, 32'h0);
        check("rst_pc4", if_id_pc_plus4, 32'h0);

        rst_n = 1'b1;
        step();
        check("boot_pc1", rom_addr, 32'h8000_0004);
        check("boot_pc4", if_id_pc_plus4, 32'h8000_0004);
        check("boot_valid", {31'h0, if_id_valid}, 32'h1);
        check("boot_instr", if_id_instr, rom_fn(32'h8000_0000));
        step();
        check("boot_pc2", rom_addr, 32'h8000_0008);

        irq = 1; step(); clr();
        check("kirq_pc", pc, 32'h8000_000C);
        check("kirq_bubble", {31'h0, if_id_irq}, 32'h0);

        jr_to(32'h0000_000C);
        check("jr_pc", pc, 32'h0000_000C);
        check("jr_flush", {31'h0, if_id_valid}, 32'h0);
        step();
        check("jr_next", pc, 32'h0000_0010);
        check("jr_refill", {31'h0, if_id_valid}, 32'h1);

        jr_to(32'h0000_0100);
        irq = 1; step(); clr();
        check("uirq_pc", pc, 32'h8000_0008);
        check("uirq_bubble", {31'h0, if_id_irq}, 32'h1);
        check("uirq_pc4", if_id_pc_plus4, 32'h0000_0104);
        irq = 1; step(); clr();
        check("uirq_kern", pc, 32'h8000_000C);

        jr_to(32'h0000_003C);
        step();
        held = if_id_instr;
        check("stall_setup", held, rom_fn(32'h0000_003C));
        repeat (2) begin
            stall = 1; step(); clr();
            check("stall_pc", pc, 32'h0000_0040);
            check("stall_instr", if_id_instr, held);
        end
        stall = 1; ex_branch_taken = 1; ex_branch_target = 32'h8000_0080; step(); clr();
        check("stall_br_pc", pc, 32'h0000_0080);
        check("stall_br_flush", {31'h0, if_id_valid}, 32'h0);

        id_exception = 1; ex_branch_taken = 1; ex_branch_target = 32'h0000_0200; irq = 1;
        step(); clr();
        check("exc_pc", pc, 32'h8000_0004);
        irq = 1; step(); clr();
        check("exc_noirq_pc", pc, 32'h8000_0008);
        check("exc_noirq_bubble", {31'h0, if_id_irq}, 32'h0);

        id_jump = 1; id_jump_idx = 26'h000_0100; step(); clr();
        check("jump_pc", pc, 32'h8000_0400);

        jr_to(32'h7FFF_FFFC); step();
        check("wrap_user", pc, 32'h0000_0000);
        jr_to(32'hFFFF_FFFC); step();
        check("wrap_kern", pc, 32'h8000_0000);

        step();
        @(posedge clk);
        #2;
        id_jump = 1; id_jump_idx = 26'h3FF_FFFF; rst_n = 1'b0;
        #1;
        check("arst_pc", pc, 32'h8000_0000);
        check("arst_valid", {31'h0, if_id_valid}, 32'h0);
        check("arst_instr", if_id_instr, 32'h0);
        check("arst_pc4", if_id_pc_plus4, 32'h0);
        @(negedge clk);
        clr();
        rst_n = 1'b1;

        for (int i = 0; i < 3000; i++) begin
            id_exception     = ($urandom_range(99) < 3);
            ex_branch_taken  = ($urandom_range(99) < 6);
            ex_branch_target = $urandom & 32'hFFFF_FFFC;
            stall            = ($urandom_range(99) < 15);
            id_jr            = ($urandom_range(99) < 6);
            id_jr_target     = ($urandom & 32'h7FFF_FFFC) |
                               (($urandom_range(9) < 3) ? 32'h8000_0000 : 32'h0);
            id_jump          = ($urandom_range(99) < 6);
            id_jump_idx      = 26'($urandom);
            irq              = ($urandom_range(99) < 40);
            step();
        end
        clr();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_if_fetch_stage
`default_nettype wire
